// File: rtl/vga_pkg.sv
// vga_pkg: shared definitions for the VGA cursor display.
//   - Default 640x480@60 timing constants (25 MHz pixel clock from 100 MHz).
//   - h_total / v_total helpers that sum the four timing segments.
//   - clamp_move: one-axis cursor step that saturates at 0 and at max_pos.
//   - rgb_t: default-width {red, green, blue} pixel.
//   - btn_idx_e: bit positions of the five buttons in the packed button vector.
package vga_pkg;

    localparam int unsigned DEF_H_ACTIVE = 640;
    localparam int unsigned DEF_H_FP     = 16;
    localparam int unsigned DEF_H_SYNC   = 96;
    localparam int unsigned DEF_H_BP     = 48;
    localparam int unsigned DEF_V_ACTIVE = 480;
    localparam int unsigned DEF_V_FP     = 10;
    localparam int unsigned DEF_V_SYNC   = 2;
    localparam int unsigned DEF_V_BP     = 33;
    localparam int unsigned DEF_CLK_DIV  = 4;
    localparam int unsigned DEF_COLOR_W  = 4;

    typedef struct packed {
        logic [DEF_COLOR_W-1:0] red;
        logic [DEF_COLOR_W-1:0] green;
        logic [DEF_COLOR_W-1:0] blue;
    } rgb_t;

    typedef enum logic [2:0] {
        BTN_UP     = 3'd0,
        BTN_DOWN   = 3'd1,
        BTN_LEFT   = 3'd2,
        BTN_RIGHT  = 3'd3,
        BTN_CENTER = 3'd4
    } btn_idx_e;

    localparam int unsigned BTN_N = 5;

    function automatic int unsigned h_total(input int unsigned act, input int unsigned fp,
                                            input int unsigned sync, input int unsigned bp);
        return act + fp + sync + bp;
    endfunction

    function automatic int unsigned v_total(input int unsigned act, input int unsigned fp,
                                            input int unsigned sync, input int unsigned bp);
        return act + fp + sync + bp;
    endfunction

    // Opposing buttons cancel; a move never wraps past either edge.
    function automatic int unsigned clamp_move(input int unsigned pos, input logic dec,
                                               input logic inc, input int unsigned step,
                                               input int unsigned max_pos);
        int unsigned res;
        res = pos;
        if (dec && !inc) begin
            if (pos < step) begin
                res = 32'd0;
            end else begin
                res = pos - step;
            end
        end else if (inc && !dec) begin
            if (pos + step > max_pos) begin
                res = max_pos;
            end else begin
                res = pos + step;
            end
        end else begin
            res = pos;
        end
        return res;
    endfunction

endpackage

// File: rtl/vga_timing.sv
// vga_timing: pixel-enable divider and raster counters.
//   clk, rst      : system clock, synchronous active-high reset
//   h_cnt_r       : horizontal pixel counter, 0 .. H_TOTAL-1
//   v_cnt_r       : vertical line counter, 0 .. V_TOTAL-1
//   hsync_win_s   : h_cnt_r inside the hsync window (combinational)
//   vsync_win_s   : v_cnt_r inside the vsync window (combinational)
//   active_s      : current position is in the visible area
//   frame_tick_s  : pixel tick that wraps the raster back to (0,0)
// All decodes are combinational from the current counters; the top
// registers them together so the syncs and colour stay aligned.
module vga_timing
    import vga_pkg::*;
#(
    parameter int unsigned H_ACTIVE = DEF_H_ACTIVE,
    parameter int unsigned H_FP     = DEF_H_FP,
    parameter int unsigned H_SYNC   = DEF_H_SYNC,
    parameter int unsigned H_BP     = DEF_H_BP,
    parameter int unsigned V_ACTIVE = DEF_V_ACTIVE,
    parameter int unsigned V_FP     = DEF_V_FP,
    parameter int unsigned V_SYNC   = DEF_V_SYNC,
    parameter int unsigned V_BP     = DEF_V_BP,
    parameter int unsigned CLK_DIV  = DEF_CLK_DIV,
    localparam int unsigned H_TOTAL = h_total(H_ACTIVE, H_FP, H_SYNC, H_BP),
    localparam int unsigned V_TOTAL = v_total(V_ACTIVE, V_FP, V_SYNC, V_BP),
    localparam int unsigned HW      = $clog2(H_TOTAL),
    localparam int unsigned VW      = $clog2(V_TOTAL)
) (
    input  logic          clk,
    input  logic          rst,
    output logic [HW-1:0] h_cnt_r,
    output logic [VW-1:0] v_cnt_r,
    output logic          hsync_win_s,
    output logic          vsync_win_s,
    output logic          active_s,
    output logic          frame_tick_s
);

    // A one-bit divider is kept for CLK_DIV = 1; it then sits at 0 and pe stays high.
    localparam int unsigned DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int unsigned HS_BEG  = H_ACTIVE + H_FP;
    localparam int unsigned HS_END  = H_ACTIVE + H_FP + H_SYNC;
    localparam int unsigned VS_BEG  = V_ACTIVE + V_FP;
    localparam int unsigned VS_END  = V_ACTIVE + V_FP + V_SYNC;

    logic [DIV_W-1:0] div_r;
    logic [DIV_W-1:0] div_nxt_s;
    logic [HW-1:0]    h_nxt_s;
    logic [VW-1:0]    v_nxt_s;
    logic             pe_s;
    logic             h_last_s;
    logic             v_last_s;

    assign pe_s         = (div_r == DIV_W'(CLK_DIV - 1));
    assign h_last_s     = (h_cnt_r == HW'(H_TOTAL - 1));
    assign v_last_s     = (v_cnt_r == VW'(V_TOTAL - 1));
    assign frame_tick_s = pe_s && h_last_s && v_last_s;

    assign hsync_win_s  = (h_cnt_r >= HW'(HS_BEG)) && (h_cnt_r < HW'(HS_END));
    assign vsync_win_s  = (v_cnt_r >= VW'(VS_BEG)) && (v_cnt_r < VW'(VS_END));
    assign active_s     = (h_cnt_r < HW'(H_ACTIVE)) && (v_cnt_r < VW'(V_ACTIVE));

    // Next divider and raster position; counters only move on a pixel tick
    always_comb begin
        div_nxt_s = div_r;
        h_nxt_s   = h_cnt_r;
        v_nxt_s   = v_cnt_r;
        if (pe_s) begin
            div_nxt_s = {DIV_W{1'b0}};
            if (h_last_s) begin
                h_nxt_s = {HW{1'b0}};
                if (v_last_s) begin
                    v_nxt_s = {VW{1'b0}};
                end else begin
                    v_nxt_s = v_cnt_r + VW'(1);
                end
            end else begin
                h_nxt_s = h_cnt_r + HW'(1);
            end
        end else begin
            div_nxt_s = div_r + DIV_W'(1);
        end
    end

    // Divider and raster counter registers
    always_ff @(posedge clk) begin
        if (rst) begin
            div_r   <= {DIV_W{1'b0}};
            h_cnt_r <= {HW{1'b0}};
            v_cnt_r <= {VW{1'b0}};
        end else begin
            div_r   <= div_nxt_s;
            h_cnt_r <= h_nxt_s;
            v_cnt_r <= v_nxt_s;
        end
    end

endmodule

// File: rtl/vga_cursor_display.sv
// vga_cursor_display: VGA output stage with a button-driven square cursor.
//   clk, rst           : system clock, synchronous active-high reset
//   btn_up/down/left/right/center : asynchronous board buttons
//   vga_red/green/blue : registered colour channels, COLOR_W bits each
//   hsync, vsync       : registered syncs, asserted level SYNC_POL
//   frame_start        : one-clk pulse on the pixel tick that enters (0,0)
// Optional build macro VGA_GRID_EN: draws a half-scale grid every 64
// pixels/lines under the cursor (needs at least 64-pixel/line rasters).
// Without it the background is black and no grid logic exists.
module vga_cursor_display
    import vga_pkg::*;
#(
    parameter int unsigned H_ACTIVE = DEF_H_ACTIVE,
    parameter int unsigned H_FP     = DEF_H_FP,
    parameter int unsigned H_SYNC   = DEF_H_SYNC,
    parameter int unsigned H_BP     = DEF_H_BP,
    parameter int unsigned V_ACTIVE = DEF_V_ACTIVE,
    parameter int unsigned V_FP     = DEF_V_FP,
    parameter int unsigned V_SYNC   = DEF_V_SYNC,
    parameter int unsigned V_BP     = DEF_V_BP,
    parameter int unsigned CLK_DIV  = DEF_CLK_DIV,
    parameter logic        SYNC_POL = 1'b0,
    parameter int unsigned COLOR_W  = DEF_COLOR_W,
    parameter int unsigned BOX_SIZE = 32,
    parameter int unsigned STEP     = 4,
    parameter logic [3*COLOR_W-1:0] BOX_RGB = 12'hF80
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               btn_up,
    input  logic               btn_down,
    input  logic               btn_left,
    input  logic               btn_right,
    input  logic               btn_center,
    output logic [COLOR_W-1:0] vga_red,
    output logic [COLOR_W-1:0] vga_green,
    output logic [COLOR_W-1:0] vga_blue,
    output logic               hsync,
    output logic               vsync,
    output logic               frame_start
);

    localparam int unsigned H_TOTAL  = h_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int unsigned V_TOTAL  = v_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
    localparam int unsigned HW       = $clog2(H_TOTAL);
    localparam int unsigned VW       = $clog2(V_TOTAL);
    localparam int unsigned HX       = HW + 1;
    localparam int unsigned VX       = VW + 1;
    localparam int unsigned PIX_W    = 3 * COLOR_W;
    localparam int unsigned X_MAX    = H_ACTIVE - BOX_SIZE;
    localparam int unsigned Y_MAX    = V_ACTIVE - BOX_SIZE;
    localparam int unsigned X_CENTER = X_MAX / 2;
    localparam int unsigned Y_CENTER = Y_MAX / 2;
    localparam logic [PIX_W-1:0] PIX_BLACK = {PIX_W{1'b0}};

    logic [HW-1:0]    h_cnt_s;
    logic [VW-1:0]    v_cnt_s;
    logic             hsync_win_s;
    logic             vsync_win_s;
    logic             active_s;
    logic             frame_tick_s;

    logic [BTN_N-1:0] btn_raw_s;
    logic [BTN_N-1:0] btn_meta_r;
    logic [BTN_N-1:0] btn_sync_r;

    logic [HW-1:0]    box_x_r;
    logic [VW-1:0]    box_y_r;
    logic [HW-1:0]    box_x_nxt_s;
    logic [VW-1:0]    box_y_nxt_s;
    logic             in_box_s;

    logic [PIX_W-1:0] pix_nxt_s;
    logic [PIX_W-1:0] pix_r;
    logic             hsync_r;
    logic             vsync_r;
    logic             frame_start_r;

    vga_timing #(
        .H_ACTIVE (H_ACTIVE),
        .H_FP     (H_FP),
        .H_SYNC   (H_SYNC),
        .H_BP     (H_BP),
        .V_ACTIVE (V_ACTIVE),
        .V_FP     (V_FP),
        .V_SYNC   (V_SYNC),
        .V_BP     (V_BP),
        .CLK_DIV  (CLK_DIV)
    ) u_timing (
        .clk          (clk),
        .rst          (rst),
        .h_cnt_r      (h_cnt_s),
        .v_cnt_r      (v_cnt_s),
        .hsync_win_s  (hsync_win_s),
        .vsync_win_s  (vsync_win_s),
        .active_s     (active_s),
        .frame_tick_s (frame_tick_s)
    );

    // Bit order follows btn_idx_e
    assign btn_raw_s = {btn_center, btn_right, btn_left, btn_down, btn_up};

    // Two-stage synchroniser for the asynchronous buttons
    always_ff @(posedge clk) begin
        if (rst) begin
            btn_meta_r <= {BTN_N{1'b0}};
            btn_sync_r <= {BTN_N{1'b0}};
        end else begin
            btn_meta_r <= btn_raw_s;
            btn_sync_r <= btn_meta_r;
        end
    end

    // Cursor position for the next frame; buttons are only looked at on the
    // frame tick, which also acts as the debounce sample rate
    always_comb begin
        box_x_nxt_s = box_x_r;
        box_y_nxt_s = box_y_r;
        if (frame_tick_s) begin
            if (btn_sync_r[BTN_CENTER]) begin
                box_x_nxt_s = HW'(X_CENTER);
                box_y_nxt_s = VW'(Y_CENTER);
            end else begin
                box_x_nxt_s = HW'(clamp_move(32'(box_x_r), btn_sync_r[BTN_LEFT],
                                             btn_sync_r[BTN_RIGHT], STEP, X_MAX));
                box_y_nxt_s = VW'(clamp_move(32'(box_y_r), btn_sync_r[BTN_UP],
                                             btn_sync_r[BTN_DOWN], STEP, Y_MAX));
            end
        end else begin
            box_x_nxt_s = box_x_r;
            box_y_nxt_s = box_y_r;
        end
    end

    // Cursor position registers
    always_ff @(posedge clk) begin
        if (rst) begin
            box_x_r <= HW'(X_CENTER);
            box_y_r <= VW'(Y_CENTER);
        end else begin
            box_x_r <= box_x_nxt_s;
            box_y_r <= box_y_nxt_s;
        end
    end

    // One extra bit so box + BOX_SIZE cannot overflow at the right/bottom edge
    assign in_box_s = ({1'b0, h_cnt_s} >= {1'b0, box_x_r}) &&
                      ({1'b0, h_cnt_s} <  ({1'b0, box_x_r} + HX'(BOX_SIZE))) &&
                      ({1'b0, v_cnt_s} >= {1'b0, box_y_r}) &&
                      ({1'b0, v_cnt_s} <  ({1'b0, box_y_r} + VX'(BOX_SIZE)));

`ifdef VGA_GRID_EN
    localparam logic [PIX_W-1:0] PIX_GRID = {3{1'b1, {(COLOR_W-1){1'b0}}}};
    logic grid_s;
    assign grid_s = (h_cnt_s[5:0] == 6'd0) || (v_cnt_s[5:0] == 6'd0);
`endif

    // Pixel colour: cursor over background, forced black during blanking
    always_comb begin
        pix_nxt_s = PIX_BLACK;
        if (active_s) begin
            if (in_box_s) begin
                pix_nxt_s = BOX_RGB;
            end else begin
`ifdef VGA_GRID_EN
                if (grid_s) begin
                    pix_nxt_s = PIX_GRID;
                end else begin
                    pix_nxt_s = PIX_BLACK;
                end
`else
                pix_nxt_s = PIX_BLACK;
`endif
            end
        end else begin
            pix_nxt_s = PIX_BLACK;
        end
    end

    // Output registers: colour, syncs and frame pulse share one clk of latency
    always_ff @(posedge clk) begin
        if (rst) begin
            pix_r         <= PIX_BLACK;
            hsync_r       <= ~SYNC_POL;
            vsync_r       <= ~SYNC_POL;
            frame_start_r <= 1'b0;
        end else begin
            pix_r         <= pix_nxt_s;
            hsync_r       <= hsync_win_s ? SYNC_POL : ~SYNC_POL;
            vsync_r       <= vsync_win_s ? SYNC_POL : ~SYNC_POL;
            frame_start_r <= frame_tick_s;
        end
    end

    assign vga_red     = pix_r[PIX_W-1 -: COLOR_W];
    assign vga_green   = pix_r[2*COLOR_W-1 -: COLOR_W];
    assign vga_blue    = pix_r[COLOR_W-1:0];
    assign hsync       = hsync_r;
    assign vsync       = vsync_r;
    assign frame_start = frame_start_r;

endmodule

// File: tb/tb_vga_cursor_display.sv
// Testbench for vga_cursor_display on a shrunk raster (24x17 totals, CLK_DIV=3).
// A reference process derives every expected output from the elapsed clock
// count and the cursor rules, pushing one expectation per clock into a queue;
// a monitor pops on the opposite edge and compares, and separately measures
// sync periods/widths and frame_start spacing directly from the waveforms.
module tb_vga_cursor_display;
    import vga_pkg::*;

    localparam int HA = 16, HF = 2, HS = 3, HB = 3;
    localparam int VA = 12, VF = 1, VS = 2, VB = 2;
    localparam int D = 3, BOX = 4, STP = 4;
    localparam int HT = HA + HF + HS + HB;
    localparam int VT = VA + VF + VS + VB;
    localparam int FPIX = HT * VT;
    localparam int FRAME = FPIX * D;
    localparam int XM = HA - BOX, YM = VA - BOX;
    localparam int XC = XM / 2, YC = YM / 2;
    localparam rgb_t BOX_C = 12'hF80;

    localparam logic [4:0] B_UP = 5'b00001, B_DN = 5'b00010, B_LF = 5'b00100;
    localparam logic [4:0] B_RT = 5'b01000, B_CT = 5'b10000, B_NONE = 5'b00000;

    logic       clk, rst;
    logic [4:0] btn;
    logic [3:0] vga_red, vga_green, vga_blue;
    logic       hsync, vsync, frame_start;

    typedef struct packed {
        logic [11:0] rgb;
        logic        hs;
        logic        vs;
        logic        fs;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   passes = 0;
    int   rst_count = 0;
    int   fs_expected = 0;
    int   fs_seen = 0;

    vga_cursor_display #(
        .H_ACTIVE (HA), .H_FP (HF), .H_SYNC (HS), .H_BP (HB),
        .V_ACTIVE (VA), .V_FP (VF), .V_SYNC (VS), .V_BP (VB),
        .CLK_DIV  (D),  .SYNC_POL (1'b0), .COLOR_W (4),
        .BOX_SIZE (BOX), .STEP (STP), .BOX_RGB (BOX_C)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .btn_up      (btn[0]),
        .btn_down    (btn[1]),
        .btn_left    (btn[2]),
        .btn_right   (btn[3]),
        .btn_center  (btn[4]),
        .vga_red     (vga_red),
        .vga_green   (vga_green),
        .vga_blue    (vga_blue),
        .hsync       (hsync),
        .vsync       (vsync),
        .frame_start (frame_start)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got === want) begin
            passes++;
        end else begin
            $display("FAIL %s @%0t: got %h expected %h", name, $time, got, want);
        end
    endtask

    // Reference: outputs after n clocks since reset release reflect the raster
    // position after n-1 clocks, i.e. floor((n-1)/D) pixel ticks.
    initial begin : model
        int   n, bx, by, t, p, h, v;
        exp_t e;
        n = 0; bx = XC; by = YC;
        forever begin
            @(posedge clk);
            if (rst) begin
                n = 0; bx = XC; by = YC;
                e.rgb = 12'h000; e.hs = 1'b1; e.vs = 1'b1; e.fs = 1'b0;
                rst_count++;
            end else begin
                n++;
                t = (n - 1) / D;
                p = t % FPIX;
                h = p % HT;
                v = p / HT;
                e.hs = !((h >= HA + HF) && (h < HA + HF + HS));
                e.vs = !((v >= VA + VF) && (v < VA + VF + VS));
                if (h < HA && v < VA && h >= bx && h < bx + BOX && v >= by && v < by + BOX)
                    e.rgb = BOX_C;
                else
                    e.rgb = 12'h000;
                e.fs = ((n % D) == 0) && (((n / D) % FPIX) == 0);
                if (e.fs) begin
                    fs_expected++;
                    if (btn[4]) begin
                        bx = XC; by = YC;
                    end else begin
                        if (btn[2] && !btn[3]) bx = (bx < STP) ? 0 : bx - STP;
                        else if (btn[3] && !btn[2]) bx = (bx + STP > XM) ? XM : bx + STP;
                        if (btn[0] && !btn[1]) by = (by < STP) ? 0 : by - STP;
                        else if (btn[1] && !btn[0]) by = (by + STP > YM) ? YM : by + STP;
                    end
                end
            end
            exp_q.push_back(e);
        end
    end

    // Monitor: pop-and-compare plus direct timing measurements
    initial begin : monitor
        exp_t e, got;
        int   clk_n, seen_rst, rst_at, last_fs, hfall, vfall;
        logic phs, pvs;
        clk_n = 0; seen_rst = 0; rst_at = 0; last_fs = -1; hfall = -1; vfall = -1;
        phs = 1'b1; pvs = 1'b1;
        forever begin
            @(negedge clk);
            clk_n++;
            if (exp_q.size() == 0) begin
                check("queue_empty", 32'd1, 32'd0);
            end else begin
                e = exp_q.pop_front();
                got = {vga_red, vga_green, vga_blue, hsync, vsync, frame_start};
                check("stream", 32'(got), 32'(e));
            end
            if (rst_count != seen_rst) begin
                seen_rst = rst_count; rst_at = clk_n;
                last_fs = -1; hfall = -1; vfall = -1;
            end else begin
                if (phs && !hsync) begin
                    if (hfall >= 0) check("hsync_period", clk_n - hfall, HT * D);
                    hfall = clk_n;
                end
                if (!phs && hsync && hfall >= 0) check("hsync_width", clk_n - hfall, HS * D);
                if (pvs && !vsync) begin
                    if (vfall >= 0) check("vsync_period", clk_n - vfall, FRAME);
                    vfall = clk_n;
                end
                if (!pvs && vsync && vfall >= 0) check("vsync_width", clk_n - vfall, VS * HT * D);
                if (frame_start) begin
                    fs_seen++;
                    if (last_fs >= 0) check("fs_period", clk_n - last_fs, FRAME);
                    else check("fs_after_reset", clk_n - rst_at, FRAME);
                    last_fs = clk_n;
                end
            end
            phs = hsync;
            pvs = vsync;
        end
    end

    // Buttons change only mid-frame, well away from the frame sample point
    task automatic step(input logic [4:0] b, input int frames);
        btn = b;
        repeat (frames * FRAME) @(negedge clk);
    endtask

    initial begin : stim
        logic [4:0] r;
        rst = 1'b1;
        btn = B_NONE;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (FRAME / 2) @(negedge clk);
        step(B_NONE, 2);
        step(B_RT, 4);          // 6 -> 10 -> 12, then held at the right edge
        step(B_LF, 1);          // 12 -> 8
        step(B_UP | B_DN, 2);   // y unchanged
        step(B_LF | B_RT, 2);   // x unchanged
        step(B_DN, 2);          // y 4 -> 8, saturate
        step(B_UP | B_LF, 3);   // diagonal to (0,0), saturate
        step(B_CT | B_LF, 1);   // centre wins
        step(B_NONE, 1);
        for (int i = 0; i < 10; i++) begin
            r = 5'($urandom_range(0, 31));
            if (r[4] && ($urandom_range(0, 2) != 0)) r[4] = 1'b0;
            step(r, 1);
        end
        repeat ($urandom_range(50, 500)) @(negedge clk);
        rst = 1'b1;
        btn = B_NONE;
        @(negedge clk);
        rst = 1'b0;
        repeat (FRAME / 2) @(negedge clk);
        step(B_RT, 2);
        step(B_NONE, 2);
        repeat (3) @(negedge clk);
        check("fs_count", fs_seen, fs_expected);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
